// File: rtl/mem_stage_unit.sv
// rtl/mem_stage_unit.sv - MEM pipeline stage: big-endian data RAM, writeback select, MEM_WB register
//
// Purpose:
//   Performs byte/word loads and stores against an internal big-endian data RAM,
//   selects the writeback value (memory read or ALU result), exports that value
//   combinationally for forwarding, and registers it into the MEM_WB stage.
//
// Ports:
//   clk              in   1   pipeline clock, rising edge
//   reset            in   1   asynchronous, active-high; clears MEM_WB only
//   rf_en            in   1   register-file write enable from EXE_MEM
//   datamem_en       in   1   data memory access enable
//   readwrite        in   1   1 = store, 0 = load
//   size             in   1   1 = word (32b), 0 = byte (8b)
//   load_instruction in   1   1 = writeback value comes from memory
//   alu_result       in   32  memory address, or writeback value for non-loads
//   store_data       in   32  data to store
//   rd               in   4   destination register
//   fwd_data         out  32  combinational writeback value (forwarding path)
//   rf_en_out        out  1   MEM_WB register-file write enable
//   wb_data_out      out  32  MEM_WB writeback value
//   rd_out           out  4   MEM_WB destination register

module mem_stage_unit #(
    parameter int ADDR_BITS = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rf_en,
    input  logic        datamem_en,
    input  logic        readwrite,
    input  logic        size,
    input  logic        load_instruction,
    input  logic [31:0] alu_result,
    input  logic [31:0] store_data,
    input  logic [3:0]  rd,
    output logic [31:0] fwd_data,
    output logic        rf_en_out,
    output logic [31:0] wb_data_out,
    output logic [3:0]  rd_out
);

    localparam int DEPTH = 2 ** ADDR_BITS;

    // Byte-wide RAM; left unreset so contents survive reset and can be preloaded.
    logic [7:0] Mem [0:DEPTH-1];

    logic [ADDR_BITS-1:0] ea;
    logic [ADDR_BITS-1:0] ea_b1;
    logic [ADDR_BITS-1:0] ea_b2;
    logic [ADDR_BITS-1:0] ea_b3;
    logic [31:0]          read_value;

    // Upper address bits are dropped, so accesses wrap within the RAM.
    // Word accesses are forced to a 4-byte boundary.
    always_comb begin
        ea = alu_result[ADDR_BITS-1:0];
        if (size) begin
            ea[1:0] = 2'b00;
        end
    end

    // Byte lanes of an aligned word; only meaningful when size = 1.
    assign ea_b1 = {ea[ADDR_BITS-1:2], 2'd1};
    assign ea_b2 = {ea[ADDR_BITS-1:2], 2'd2};
    assign ea_b3 = {ea[ADDR_BITS-1:2], 2'd3};

    // Written at the edge that ends the store, so a load in the following
    // cycle already sees the new data. Reset does not gate the write.
    always_ff @(posedge clk) begin
        if (datamem_en && readwrite) begin
            if (size) begin
                Mem[ea]    <= store_data[31:24];
                Mem[ea_b1] <= store_data[23:16];
                Mem[ea_b2] <= store_data[15:8];
                Mem[ea_b3] <= store_data[7:0];
            end else begin
                Mem[ea]    <= store_data[7:0];
            end
        end
    end

    // Big-endian read: lowest address is the most significant byte.
    always_comb begin
        read_value = 32'd0;
        if (datamem_en && !readwrite) begin
            if (size) begin
                read_value = {Mem[ea], Mem[ea_b1], Mem[ea_b2], Mem[ea_b3]};
            end else begin
                read_value = {24'd0, Mem[ea]};
            end
        end
    end

    assign fwd_data = load_instruction ? read_value : alu_result;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rf_en_out   <= 1'b0;
            wb_data_out <= 32'd0;
            rd_out      <= 4'd0;
        end else begin
            rf_en_out   <= rf_en;
            wb_data_out <= fwd_data;
            rd_out      <= rd;
        end
    end

endmodule

// File: tb/tb_mem_stage_unit.sv
// tb/tb_mem_stage_unit.sv - directed self-checking bench for mem_stage_unit

module tb_mem_stage_unit;

    logic        clk;
    logic        reset;
    logic        rf_en;
    logic        datamem_en;
    logic        readwrite;
    logic        size;
    logic        load_instruction;
    logic [31:0] alu_result;
    logic [31:0] store_data;
    logic [3:0]  rd;
    logic [31:0] fwd_data;
    logic        rf_en_out;
    logic [31:0] wb_data_out;
    logic [3:0]  rd_out;

    int n_checks;
    int n_fail;

    mem_stage_unit #(.ADDR_BITS(8)) dut (
        .clk              (clk),
        .reset            (reset),
        .rf_en            (rf_en),
        .datamem_en       (datamem_en),
        .readwrite        (readwrite),
        .size             (size),
        .load_instruction (load_instruction),
        .alu_result       (alu_result),
        .store_data       (store_data),
        .rd               (rd),
        .fwd_data         (fwd_data),
        .rf_en_out        (rf_en_out),
        .wb_data_out      (wb_data_out),
        .rd_out           (rd_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Present one MEM-stage operation; leaves time before the next edge for
    // combinational checks.
    task automatic drive(input logic r_en, input logic d_en, input logic rw, input logic sz,
                         input logic ld, input logic [31:0] alu, input logic [31:0] sd,
                         input logic [3:0] r);
        rf_en            = r_en;
        datamem_en       = d_en;
        readwrite        = rw;
        size             = sz;
        load_instruction = ld;
        alu_result       = alu;
        store_data       = sd;
        rd               = r;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b1;
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h1111_2222, 32'h0, 4'hF);

        // Reset held: MEM_WB stays clear even with rf_en/rd driven.
        tick();
        tick();
        check_eq("rst_rf_en",  {31'd0, rf_en_out}, 32'd0);
        check_eq("rst_wb",     wb_data_out,        32'd0);
        check_eq("rst_rd",     {28'd0, rd_out},    32'd0);
        reset = 1'b0;

        // Clear the word at 0x20 so test 3's word view is known.
        drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0000_0020, 32'h0000_0000, 4'd0);
        tick();

        // Word store then immediate word load.
        drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0000_0010, 32'hDEAD_BEEF, 4'd0);
        tick();
        drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0010, 32'h0, 4'd3);
        check_eq("wld_fwd", fwd_data, 32'hDEAD_BEEF);
        tick();
        check_eq("wld_wb",    wb_data_out,        32'hDEAD_BEEF);
        check_eq("wld_rd",    {28'd0, rd_out},    32'd3);
        check_eq("wld_rf_en", {31'd0, rf_en_out}, 32'd1);
        check_eq("mem_10", {24'd0, dut.Mem[8'h10]}, 32'h0000_00DE);
        check_eq("mem_11", {24'd0, dut.Mem[8'h11]}, 32'h0000_00AD);
        check_eq("mem_12", {24'd0, dut.Mem[8'h12]}, 32'h0000_00BE);
        check_eq("mem_13", {24'd0, dut.Mem[8'h13]}, 32'h0000_00EF);

        // Byte store keeps only the low byte; byte load zero-extends.
        drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_0021, 32'h1234_56A5, 4'd0);
        tick();
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0021, 32'h0, 4'd4);
        tick();
        check_eq("bld_21", wb_data_out, 32'h0000_00A5);
        drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0020, 32'h0, 4'd4);
        tick();
        check_eq("wld_20", wb_data_out, 32'h00A5_0000);

        // Unaligned word address is aligned down; upper address bits wrap.
        drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0013, 32'h0, 4'd5);
        tick();
        check_eq("wld_13_align", wb_data_out, 32'hDEAD_BEEF);
        drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0110, 32'h0, 4'd5);
        tick();
        check_eq("wld_110_wrap", wb_data_out, 32'hDEAD_BEEF);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'hFFFF_FF11, 32'h0, 4'd5);
        tick();
        check_eq("bld_wrap_11", wb_data_out, 32'h0000_00AD);

        // Non-load passes the ALU result through.
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0055, 32'h0, 4'd7);
        check_eq("alu_fwd", fwd_data, 32'h0000_0055);
        tick();
        check_eq("alu_rf_en", {31'd0, rf_en_out}, 32'd1);
        check_eq("alu_wb",    wb_data_out,        32'h0000_0055);
        check_eq("alu_rd",    {28'd0, rd_out},    32'd7);

        // Disabled store must not touch RAM; disabled load reads zero.
        drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_0030, 32'h0000_003C, 4'd0);
        tick();
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0030, 32'h0000_00FF, 4'd0);
        tick();
        check_eq("mem_30_kept", {24'd0, dut.Mem[8'h30]}, 32'h0000_003C);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0030, 32'h0, 4'd2);
        tick();
        check_eq("bld_30", wb_data_out, 32'h0000_003C);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0030, 32'h0, 4'd2);
        tick();
        check_eq("ld_disabled", wb_data_out, 32'h0000_0000);
        // load_instruction with a store: read path is forced to zero.
        drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'd0);
        check_eq("store_ld_fwd", fwd_data, 32'h0000_0000);

        // Mid-run async reset clears MEM_WB between edges.
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0099, 32'h0, 4'd9);
        tick();
        check_eq("pre_rst_wb", wb_data_out, 32'h0000_0099);
        #2;
        reset = 1'b1;
        #1;
        check_eq("async_rf_en", {31'd0, rf_en_out}, 32'd0);
        check_eq("async_wb",    wb_data_out,        32'd0);
        check_eq("async_rd",    {28'd0, rd_out},    32'd0);

        // Store during reset is still performed; RAM survives reset.
        tick();
        drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_0040, 32'h0000_0077, 4'd0);
        tick();
        check_eq("rst_store_40", {24'd0, dut.Mem[8'h40]}, 32'h0000_0077);
        reset = 1'b0;
        drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0010, 32'h0, 4'd1);
        tick();
        check_eq("post_rst_wld", wb_data_out, 32'hDEAD_BEEF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
